// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips_mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int DATA_W     = 32;
    // Width of the latency down-counter; LATENCY must fit in it (0..15).
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } memState_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: combinational read, synchronous write.
// Latency: read 0 cycles (combinational), write commits at the clock edge.
// Backpressure: none; the responder FSM sequences every access.
// Ports: clk; wrEn/idx/wrData write port (wrBe byte enables only when
// DMEM_BYTE_STROBE_EN is defined); rdData returns the word at idx.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [ADDR_W-1:0]     idx,
    input  logic [DATA_W-1:0]     wrData,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [WORD_BYTES-1:0] wrBe,
`endif
    output logic [DATA_W-1:0]     rdData
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
`ifdef DMEM_BYTE_STROBE_EN
                if (wrBe[b]) begin
                    mem[idx][8*b +: 8] <= wrData[8*b +: 8];
                end
`else
                mem[idx][8*b +: 8] <= wrData[8*b +: 8];
`endif
            end
        end
    end

    assign rdData = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, programmable wait.
// Latency: response strobe LATENCY+2 cycles after the acceptance cycle (edge T+LATENCY+1).
// Backpressure: req_ready low outside IDLE; stall holds the pipe until the response.
// Ports: clk, rst (sync, active-high); req_valid/req_write/req_addr/req_wdata
// (+ req_be when DMEM_BYTE_STROBE_EN is defined) -> req_ready;
// resp_valid/resp_rdata/resp_err one-cycle response; stall pipeline hold.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [WORD_BYTES-1:0] req_be,
`endif
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  stall
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    memState_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       latAddr;
    logic [31:0]       latWdata;
    logic              latWrite;
`ifdef DMEM_BYTE_STROBE_EN
    logic [WORD_BYTES-1:0] latBe;
    logic [WORD_BYTES-1:0] accBe;
`endif

    logic              execNow;
    logic [31:0]       accAddr;
    logic [31:0]       accWdata;
    logic              accWrite;
    logic              misaligned;
    logic              wrEn;
    logic [DATA_W-1:0] rdData;
    logic              unusedAddrBits;

    assign req_ready = (state == IDLE) && !rst;
    assign stall     = ((state == IDLE) && req_valid) || (state == BUSY);

    // The access happens on the edge that enters RESP. With LATENCY = 0 that
    // is the acceptance edge itself, so the live request must be used because
    // the latches are only being loaded on that same edge.
    assign execNow = !rst &&
                     (((state == BUSY) && (cnt == CNT_ONE)) ||
                      ((LATENCY == 0) && (state == IDLE) && req_valid));

    always_comb begin
        accAddr  = latAddr;
        accWdata = latWdata;
        accWrite = latWrite;
`ifdef DMEM_BYTE_STROBE_EN
        accBe    = latBe;
`endif
        if (state == IDLE) begin
            accAddr  = req_addr;
            accWdata = req_wdata;
            accWrite = req_write;
`ifdef DMEM_BYTE_STROBE_EN
            accBe    = req_be;
`endif
        end
    end

    assign misaligned = (accAddr[1:0] != 2'b00);
    assign wrEn       = execNow && accWrite && !misaligned;

    // Address bits above the word index alias by wrap-around.
    assign unusedAddrBits = ^accAddr[31:ADDR_W+2];

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (clk),
        .wrEn   (wrEn),
        .idx    (accAddr[ADDR_W+1:2]),
        .wrData (accWdata),
`ifdef DMEM_BYTE_STROBE_EN
        .wrBe   (accBe),
`endif
        .rdData (rdData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        latAddr  <= req_addr;
                        latWdata <= req_wdata;
                        latWrite <= req_write;
`ifdef DMEM_BYTE_STROBE_EN
                        latBe    <= req_be;
`endif
                        cnt      <= LAT_CNT;
                        state    <= (LATENCY == 0) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Registered strobe: it is seen in the cycle after RESP.
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (execNow) begin
                resp_err   <= misaligned;
                resp_rdata <= (accWrite || misaligned) ? '0 : rdData;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and LATENCY 0).
// Latency: checks response timing and stall length per request.
// Backpressure: checks req_ready in reset, idle and acceptance cycles.
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  reqValid;
    logic [1:0]  reqWrite;
    logic [1:0][31:0] reqAddr;
    logic [1:0][31:0] reqWdata;
    logic [1:0][3:0]  reqBe;
    logic [1:0]  reqReady;
    logic [1:0]  respValid;
    logic [1:0][31:0] respRdata;
    logic [1:0]  respErr;
    logic [1:0]  stallS;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifndef DMEM_BYTE_STROBE_EN
    logic unusedBe;
    assign unusedBe = ^reqBe;
`endif

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (reqValid[0]),
        .req_write  (reqWrite[0]),
        .req_addr   (reqAddr[0]),
        .req_wdata  (reqWdata[0]),
`ifdef DMEM_BYTE_STROBE_EN
        .req_be     (reqBe[0]),
`endif
        .req_ready  (reqReady[0]),
        .resp_valid (respValid[0]),
        .resp_rdata (respRdata[0]),
        .resp_err   (respErr[0]),
        .stall      (stallS[0])
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (reqValid[1]),
        .req_write  (reqWrite[1]),
        .req_addr   (reqAddr[1]),
        .req_wdata  (reqWdata[1]),
`ifdef DMEM_BYTE_STROBE_EN
        .req_be     (reqBe[1]),
`endif
        .req_ready  (reqReady[1]),
        .resp_valid (respValid[1]),
        .resp_rdata (respRdata[1]),
        .resp_err   (respErr[1]),
        .stall      (stallS[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Drive one request on instance 'which', then follow it to its response.
    task automatic doReq(input int which, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] expData, input logic expErr);
        int   lat;
        int   sc;
        bit   seen;
        exp_t e;
        lat = (which == 0) ? 2 : 0;
        @(negedge clk);
        reqValid[which] = 1'b1;
        reqWrite[which] = wr;
        reqAddr[which]  = addr;
        reqWdata[which] = wdata;
        reqBe[which]    = be;
        e.data = expData;
        e.err  = expErr;
        sbq.push_back(e);
        #1;
        check("req_ready_idle", 32'(reqReady[which]), 32'd1);
        sc = stallS[which] ? 1 : 0;
        @(posedge clk);
        #1;
        reqValid[which] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (stallS[which]) sc++;
            if (respValid[which]) begin
                seen = 1'b1;
                check("resp_latency", 32'(k), 32'(lat + 1));
                e = sbq.pop_front();
                check("resp_rdata", respRdata[which], e.data);
                check("resp_err", 32'(respErr[which]), 32'(e.err));
            end
        end
        check("resp_seen", 32'(seen), 32'd1);
        check("stall_cycles", 32'(sc), 32'(lat + 1));
        @(negedge clk);
        check("resp_single_pulse", 32'(respValid[which]), 32'd0);
    endtask

    initial begin
        bit pulse;
        rst      = 1'b1;
        reqValid = '0;
        reqWrite = '0;
        reqAddr  = '0;
        reqWdata = '0;
        reqBe    = '0;

        // Reset behaviour.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(reqReady[0]), 32'd0);
        check("rst_req_ready0", 32'(reqReady[1]), 32'd0);
        check("rst_resp_valid", 32'(respValid[0]), 32'd0);
        check("rst_resp_rdata", respRdata[0], 32'd0);
        check("rst_stall", 32'(stallS[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_req_ready", 32'(reqReady[0]), 32'd1);
        check("idle_stall", 32'(stallS[0]), 32'd0);
        check("idle_resp_valid", 32'(respValid[0]), 32'd0);
        check("idle_resp_rdata", respRdata[0], 32'd0);

        // Store, read-after-write, alias, misaligned store/load.
        doReq(0, 1'b1, 32'h40,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
        doReq(0, 1'b0, 32'h40,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
        doReq(0, 1'b0, 32'h1040, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
        doReq(0, 1'b1, 32'h42,   32'h0BADF00D, 4'hF, 32'h0,        1'b1);
        doReq(0, 1'b0, 32'h40,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
        doReq(0, 1'b0, 32'h41,   32'h0,        4'hF, 32'h0,        1'b1);

        // Reset on the would-be commit edge of a pending store.
        doReq(0, 1'b1, 32'h80,   32'h11110000, 4'hF, 32'h0,        1'b0);
        @(negedge clk);
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b1;
        reqAddr[0]  = 32'h80;
        reqWdata[0] = 32'h12345678;
        reqBe[0]    = 4'hF;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_stall", 32'(stallS[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("busy_rst_ready", 32'(reqReady[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_stall", 32'(stallS[0]), 32'd0);
        check("post_rst_ready", 32'(reqReady[0]), 32'd1);
        pulse = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (respValid[0]) pulse = 1'b1;
        end
        check("no_resp_after_rst", 32'(pulse), 32'd0);
        doReq(0, 1'b0, 32'h80,   32'h0,        4'hF, 32'h11110000, 1'b0);

        // Zero-latency instance.
        doReq(1, 1'b1, 32'h20,   32'h55AA55AA, 4'hF, 32'h0,        1'b0);
        doReq(1, 1'b0, 32'h20,   32'h0,        4'hF, 32'h55AA55AA, 1'b0);
`ifdef DMEM_BYTE_STROBE_EN
        doReq(1, 1'b1, 32'h100,  32'h0,        4'hF, 32'h0,        1'b0);
        doReq(1, 1'b1, 32'h100,  32'hAABBCCDD, 4'h3, 32'h0,        1'b0);
        doReq(1, 1'b0, 32'h100,  32'h0,        4'hF, 32'h0000CCDD, 1'b0);
        doReq(1, 1'b1, 32'h100,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0);
        doReq(1, 1'b0, 32'h100,  32'h0,        4'hF, 32'h0000CCDD, 1'b0);
`else
        doReq(1, 1'b1, 32'h100,  32'hAABBCCDD, 4'h3, 32'h0,        1'b0);
        doReq(1, 1'b0, 32'h100,  32'h0,        4'hF, 32'hAABBCCDD, 1'b0);
`endif

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
